// File: rtl/bcd_digit_encoder.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with a clamp at 999.
// The digit outputs are updated only on the done cycle, so readers always see a consistent triple.
module bcd_digit_encoder #(
    parameter int unsigned BIN_WIDTH = 16,
    parameter int unsigned MAX_VALUE = 999
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BIN_WIDTH-1:0] bin_in,
    output logic                 busy,
    output logic                 done,
    output logic [3:0]           ones,
    output logic [3:0]           tens,
    output logic [3:0]           hundreds,
    output logic                 overflow,
    output logic [1:0]           lead_blank
);

    localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int unsigned BCD_W = 12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FIN
    } state_t;

    state_t               state;
    logic [BIN_WIDTH-1:0] shreg;
    logic [BCD_W-1:0]     bcd;
    logic [BCD_W-1:0]     bcd_adj;
    logic [CNT_W-1:0]     cnt;
    logic                 ovf;
    logic                 clamp;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // All three nibbles are corrected in parallel ahead of the shift
    always_comb begin
        bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
        clamp   = bin_in > BIN_WIDTH'(MAX_VALUE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bcd        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ones       <= 4'd0;
            tens       <= 4'd0;
            hundreds   <= 4'd0;
            overflow   <= 1'b0;
            lead_blank <= 2'b11;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy  <= 1'b1;
                        ovf   <= clamp;
                        shreg <= clamp ? BIN_WIDTH'(MAX_VALUE) : bin_in;
                        bcd   <= '0;
                        cnt   <= CNT_W'(BIN_WIDTH);
                        state <= S_SHIFT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    // Top bit of the adjusted hundreds nibble can never be set on a clamped input
                    {bcd, shreg} <= {bcd_adj[BCD_W-2:0], shreg, 1'b0};
                    cnt          <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    hundreds   <= bcd[11:8];
                    tens       <= bcd[7:4];
                    ones       <= bcd[3:0];
                    overflow   <= ovf;
                    lead_blank <= {bcd[11:8] == 4'd0, bcd[11:4] == 8'd0};
                    done       <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_digit_encoder.sv
// Scoreboard bench for bcd_digit_encoder: stimulus pushes expected digits, a negedge monitor checks them.
module tb_bcd_digit_encoder;

    localparam int unsigned BW  = 16;
    localparam int unsigned LAT = BW + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [BW-1:0] bin_in = '0;
    logic          busy, done, overflow;
    logic [3:0]    ones, tens, hundreds;
    logic [1:0]    lead_blank;

    bcd_digit_encoder #(.BIN_WIDTH(BW), .MAX_VALUE(999)) dut (
        .clock(clock), .reset(reset), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .ones(ones), .tens(tens), .hundreds(hundreds),
        .overflow(overflow), .lead_blank(lead_blank)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned val;
        logic [14:0] res;   // {hundreds, tens, ones, overflow, lead_blank}
        int          accept;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   dones = 0;
    int   issued = 0;

    logic [16:0] prev_out;
    logic        prev_done = 1'b0;
    localparam logic [16:0] RST_OUT = {1'b0, 1'b0, 12'h000, 1'b0, 2'b11};

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [16:0] cur_out();
        return {busy, done, hundreds, tens, ones, overflow, lead_blank};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: clamp, then decimal digits by plain arithmetic
    function automatic logic [14:0] model(input int unsigned v);
        int unsigned c, h, t, o;
        c = (v > 999) ? 999 : v;
        h = c / 100;
        t = (c / 10) % 10;
        o = c % 10;
        return {4'(h), 4'(t), 4'(o), v > 999, h == 0, (h == 0) && (t == 0)};
    endfunction

    // Monitor: checks every done against the scoreboard, and that outputs hold otherwise
    always @(negedge clock) begin
        if (reset) begin
            chk("reset_values", 32'(cur_out()), 32'(RST_OUT));
            prev_out = RST_OUT;
        end else begin
            if (done) begin
                if (prev_done) chk("done_single_cycle", 32'(1), 32'(0));
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(1), 32'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk($sformatf("digits_%0d", e.val), 32'(cur_out()) & 32'h7fff, 32'(e.res));
                    chk($sformatf("latency_%0d", e.val), 32'(cyc - e.accept), 32'(LAT));
                    chk("busy_in_done", 32'(busy), 32'(1));
                    dones++;
                end
            end else begin
                chk("outputs_hold", 32'(cur_out()) & 32'h7fff, 32'(prev_out) & 32'h7fff);
            end
            prev_out = cur_out();
        end
        prev_done = done;
    end

    task automatic push_exp(input int unsigned v);
        exp_t e;
        e.val    = v;
        e.res    = model(v);
        e.accept = cyc;
        sb.push_back(e);
        issued++;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (busy !== 1'b0) chk("wait_idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'(0));
            sb.delete();
        end
    endtask

    task automatic issue(input int unsigned v);
        wait_idle();
        start  = 1'b1;
        bin_in = BW'(v);
        @(posedge clock);
        #1;
        push_exp(v);
        start  = 1'b0;
        bin_in = BW'($urandom);
    endtask

    task automatic convert(input int unsigned v);
        issue(v);
        wait_drain();
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("idle_after_reset", 32'(cur_out()), 32'(RST_OUT));

        // Directed values, including the clamp boundary
        convert(0);
        convert(123);
        convert(7);
        convert(40);
        convert(999);
        convert(1000);
        convert(65535);

        // Start pulsed while busy must be ignored
        issue(456);
        repeat (5) @(negedge clock);
        start  = 1'b1;
        bin_in = BW'(789);
        @(negedge clock);
        start  = 1'b0;
        bin_in = BW'($urandom);
        wait_drain();

        // Start held: second acceptance lands on the edge where busy falls
        wait_idle();
        start  = 1'b1;
        bin_in = BW'(456);
        @(posedge clock);
        #1 push_exp(456);
        @(negedge clock);
        bin_in = BW'(789);
        repeat (LAT + 1) @(posedge clock);
        #1 push_exp(789);
        @(negedge clock);
        start = 1'b0;
        wait_drain();

        // Reset in the middle of a conversion aborts it
        issue(321);
        repeat (8) @(posedge clock);
        #2 reset = 1'b1;
        #1 chk("async_reset", 32'(cur_out()), 32'(RST_OUT));
        void'(sb.pop_back());
        issued--;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        convert(321);

        // Random sweep around the clamp plus a few full-range values
        for (int i = 0; i < 40; i++) convert($urandom_range(0, 1200));
        for (int i = 0; i < 4; i++) convert(int'($urandom_range(0, 65535)));

        repeat (4) @(negedge clock);
        chk("done_count", 32'(dones), 32'(issued));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
